wavegen_core: RTL and testbench



---
 rtl/wavegen_core.sv | 151 +++++++++++++++
 tb/tb_wavegen_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wavegen_core.sv
// wavegen_core: quadrature-tuned frequency/amplitude function generator with serial DAC framing.
module wavegen_core #(
  parameter int PHASE_W  = 24,
  parameter int FREQ_W   = 16,
  parameter int AMP_W    = 8,
  parameter int DAC_W    = 12,
  parameter int FRAME_W  = 16,
  parameter int SCLK_DIV = 2,
  parameter int GAP_CYC  = 11
) (
  input  logic              MHz50Clk,
  input  logic              reset,
  input  logic              A,
  input  logic              B,
  input  logic              s0,
  input  logic              s1,
  input  logic [1:0]        mode,
  output logic              serialClock,
  output logic              syncDAC,
  output logic              dIn,
  output logic              ldac,
  output logic [FREQ_W-1:0] fCount,
  output logic [AMP_W-1:0]  aCount,
  output logic              sampleStrobe
);
  localparam int BITP = 2 * SCLK_DIV;
  localparam int CMAX = BITP > GAP_CYC ? BITP : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(FRAME_W + 1);
  localparam int PW   = DAC_W + AMP_W;
  typedef enum logic [1:0] {LOAD, SHIFT, LDAC, GAP} state_t;
  state_t             state_q, state_d;
  logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]         ab_q, ab_d, step;
  logic [FREQ_W-1:0]  fcnt_q, fcnt_d;
  logic [AMP_W-1:0]   acnt_q, acnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d, phase_nx;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [DAC_W-1:0]   p, w, smp;
  logic               up, dn, sel_f, sel_a, bit_end;
  logic               sclk_q, sclk_d, sync_q, sync_d, ldac_q, ldac_d, din_q, din_d, strobe_q, strobe_d;

  // Gray code {A, A^B} is a 2-bit position; the position difference gives the step direction.
  always_comb begin
    sync1_d = {A, B, s0, s1};
    sync2_d = sync1_q;
    ab_d    = sync2_q[3:2];
    step    = {ab_d[1], ^ab_d} - {ab_q[1], ^ab_q};
    up      = step == 2'd1;
    dn      = step == 2'd3;
    sel_f   = sync2_q[1] & ~sync2_q[0];
    sel_a   = ~sync2_q[1] & sync2_q[0];
    fcnt_d  = (sel_f && up && fcnt_q != '1) ? fcnt_q + FREQ_W'(1) :
              (sel_f && dn && fcnt_q != FREQ_W'(1)) ? fcnt_q - FREQ_W'(1) : fcnt_q;
    acnt_d  = (sel_a && up && acnt_q != '1) ? acnt_q + AMP_W'(1) :
              (sel_a && dn && acnt_q != '0) ? acnt_q - AMP_W'(1) : acnt_q;
  end

  always_comb begin
    phase_nx = phase_q + PHASE_W'(fcnt_q);
    p        = DAC_W'(phase_nx >> (PHASE_W - DAC_W));
    w        = mode == 2'd0 ? p :
               mode == 2'd1 ? (p[DAC_W-1] ? ~{p[DAC_W-2:0], 1'b0} : {p[DAC_W-2:0], 1'b0}) :
               mode == 2'd2 ? {DAC_W{p[DAC_W-1]}} : DAC_W'(1) << (DAC_W - 1);
    smp      = DAC_W'((PW'(w) * PW'(acnt_q)) >> AMP_W);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    phase_d = phase_q;
    bit_end = cnt_q == CW'(BITP - 1);
    case (state_q)
      LOAD: begin
        phase_d = phase_nx;
        sh_d    = FRAME_W'(smp);
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
      end
      SHIFT: if (bit_end) begin
        cnt_d   = '0;
        state_d = bit_q == BW'(FRAME_W - 1) ? LDAC : SHIFT;
        bit_d   = bit_q + BW'(1);
        sh_d    = sh_q << 1;
      end
      LDAC: if (bit_end) begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: if (cnt_q == CW'(GAP_CYC - 1)) begin
        cnt_d   = '0;
        state_d = LOAD;
      end
    endcase
    // Outputs are registered decodes of the state being entered, so pins never glitch.
    sclk_d   = !(state_d == SHIFT && cnt_d >= CW'(SCLK_DIV));
    sync_d   = state_d != SHIFT;
    ldac_d   = state_d != LDAC;
    din_d    = state_d == SHIFT && sh_d[FRAME_W-1];
    strobe_d = state_q == LOAD;
  end

  always_ff @(posedge MHz50Clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      ab_q     <= '0;
      fcnt_q   <= FREQ_W'(1);
      acnt_q   <= '1;
      phase_q  <= '0;
      state_q  <= LOAD;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      sclk_q   <= 1'b1;
      sync_q   <= 1'b1;
      ldac_q   <= 1'b1;
      din_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      ab_q     <= ab_d;
      fcnt_q   <= fcnt_d;
      acnt_q   <= acnt_d;
      phase_q  <= phase_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      sclk_q   <= sclk_d;
      sync_q   <= sync_d;
      ldac_q   <= ldac_d;
      din_q    <= din_d;
      strobe_q <= strobe_d;
    end
  end

  assign serialClock  = sclk_q;
  assign syncDAC      = sync_q;
  assign dIn          = din_q;
  assign ldac         = ldac_q;
  assign fCount       = fcnt_q;
  assign aCount       = acnt_q;
  assign sampleStrobe = strobe_q;
endmodule

// File: tb/tb_wavegen_core.sv
// tb_wavegen_core: encoder vector table, serial frame scoreboard against an arithmetic waveform model.
module tb_wavegen_core;
  localparam int PER = 80;
  logic clk = 1'b0, rst = 1'b1, A = 1'b0, B = 1'b0, s0 = 1'b0, s1 = 1'b0;
  logic [1:0] mode = 2'd3;
  logic sclk, sync_n, din, ldac_n, strobe;
  logic [15:0] fcount;
  logic [7:0] acount;

  wavegen_core dut (
    .MHz50Clk(clk), .reset(rst), .A(A), .B(B), .s0(s0), .s1(s1), .mode(mode),
    .serialClock(sclk), .syncDAC(sync_n), .dIn(din), .ldac(ldac_n),
    .fCount(fcount), .aCount(acount), .sampleStrobe(strobe)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {int due; int dir; int tgt;} ev_t;
  typedef struct {int word; int md;} exp_t;
  ev_t  evq[$];
  exp_t expq[$];
  ev_t  ev;
  exp_t ep;
  logic [1:0] gray_t [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int pos = 0, cyc = 0, f_m = 1, a_m = 255, phase_m = 0;
  int snap_f, snap_a, snap_mode;

  // Encoder effects land 3 clocks after the raw edge; LOAD sees values from before its edge.
  always @(posedge clk) begin
    snap_f = f_m;
    snap_a = a_m;
    snap_mode = int'(mode);
    cyc++;
    #1;
    while (evq.size() > 0 && evq[0].due <= cyc) begin
      ev = evq.pop_front();
      if (ev.tgt == 1) f_m = (f_m + ev.dir < 1) ? 1 : (f_m + ev.dir > 65535) ? 65535 : f_m + ev.dir;
      if (ev.tgt == 2) a_m = (a_m + ev.dir < 0) ? 0 : (a_m + ev.dir > 255) ? 255 : a_m + ev.dir;
    end
  end

  int in_frame = 0, nbits, viol, frames = 0, ldac_cnt = 0, ldac_pulses = 0, last_strobe = -1;
  int p, w;
  logic [15:0] word, first_word, last_word;
  logic prev_sync = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0, seen_lo = 1'b0, seen_hi = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0; prev_sync = 1'b1; prev_sclk = 1'b1; prev_din = 1'b0; ldac_cnt = 0; last_strobe = -1;
    end else begin
      if (strobe) begin
        phase_m = (phase_m + snap_f) % (1 << 24);
        p = phase_m / 4096;
        w = snap_mode == 0 ? p :
            snap_mode == 1 ? (p < 2048 ? 2 * p : 4095 - 2 * (p - 2048)) :
            snap_mode == 2 ? (p >= 2048 ? 4095 : 0) : 2048;
        expq.push_back('{w * snap_a / 256, snap_mode});
        if (last_strobe >= 0) chk("frame_period", 32'(cyc - last_strobe), PER);
        last_strobe = cyc;
      end
      if (!sync_n && prev_sync) begin
        in_frame = 1; nbits = 0; word = '0; viol = 0;
      end else if (in_frame != 0 && !sync_n) begin
        if (prev_sclk && !sclk) begin
          word = {word[14:0], din};
          nbits++;
        end
        if (din != prev_din && !(sclk && !prev_sclk)) viol = 1;
      end
      if (sync_n && !prev_sync && in_frame != 0) begin
        in_frame = 0;
        chk("frame_bits", 32'(nbits), 16);
        chk("din_stable", 32'(viol), 0);
        if (expq.size() == 0) chk("frame_expected", 32'(expq.size()), 1);
        else begin
          ep = expq.pop_front();
          chk("frame_word", 32'(word), ep.word);
          if (ep.md == 2 && word == 16'h0000) seen_lo = 1'b1;
          if (ep.md == 2 && word == 16'h0FEF) seen_hi = 1'b1;
        end
        if (frames == 0) first_word = word;
        last_word = word;
        frames++;
      end
      if (!ldac_n) ldac_cnt++;
      else if (ldac_cnt > 0) begin
        chk("ldac_width", 32'(ldac_cnt), 4);
        ldac_pulses++;
        ldac_cnt = 0;
      end
      prev_sync = sync_n; prev_sclk = sclk; prev_din = din;
    end
  end

  task automatic set_sel(input logic a, input logic b);
    @(negedge clk);
    s0 = a; s1 = b;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_mode(input int m);
    @(negedge clk);
    mode = 2'(m);
  endtask

  task automatic turn(input int n, input int gap);
    for (int i = 0; i < (n < 0 ? -n : n); i++) begin
      repeat (gap) @(negedge clk);
      pos = (pos + (n < 0 ? 3 : 1)) % 4;
      {A, B} = gray_t[pos];
      evq.push_back('{cyc + 3, n < 0 ? -1 : 1, (s0 && !s1) ? 1 : (!s0 && s1) ? 2 : 0});
    end
  endtask

  task automatic wait_frames(input int n);
    int target = frames + n;
    for (int t = 0; t < PER * (n + 2) && frames < target; t++) @(negedge clk);
    if (frames < target) chk("frame_timeout", 32'(frames), 32'(target));
  endtask

  typedef struct {logic s0; logic s1; int steps; int gap; int exp_f; int exp_a;} kv_t;
  kv_t kv[7];
  int r, pulses0;

  initial begin
    kv[0] = '{1'b1, 1'b0,   8, 10, 9, 255};
    kv[1] = '{1'b1, 1'b0, -20, 10, 1, 255};
    kv[2] = '{1'b1, 1'b1,   5, 10, 1, 255};
    kv[3] = '{1'b0, 1'b0,   3, 10, 1, 255};
    kv[4] = '{1'b0, 1'b1, -10,  4, 1, 245};
    kv[5] = '{1'b0, 1'b1, 300,  2, 1, 255};
    kv[6] = '{1'b1, 1'b0,   3, 10, 4, 255};
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 1);
    chk("rst_sync", 32'(sync_n), 1);
    chk("rst_ldac", 32'(ldac_n), 1);
    chk("rst_din", 32'(din), 0);
    chk("rst_strobe", 32'(strobe), 0);
    chk("rst_fcount", 32'(fcount), 1);
    chk("rst_acount", 32'(acount), 255);
    @(negedge clk);
    #1 rst = 1'b0;
    wait_frames(2);
    chk("first_frame", 32'(first_word), 32'h07F8);

    for (int i = 0; i < 7; i++) begin
      set_sel(kv[i].s0, kv[i].s1);
      turn(kv[i].steps, kv[i].gap);
      repeat (6) @(negedge clk);
      chk("enc_fcount", 32'(fcount), kv[i].exp_f);
      chk("enc_acount", 32'(acount), kv[i].exp_a);
    end
    @(negedge clk);
    pos = (pos + 2) % 4;
    {A, B} = gray_t[pos];
    repeat (6) @(negedge clk);
    chk("invalid_jump", 32'(fcount), 4);

    set_mode(0);
    turn(16'h1000 - 4, 1);
    repeat (6) @(negedge clk);
    chk("saw_fcount", 32'(fcount), 32'h1000);
    wait_frames(30);

    set_mode(2);
    turn(16'h8000 - 16'h1000, 1);
    for (int t = 0; t < 300 * PER && !seen_hi; t++) @(negedge clk);
    chk("square_low_seen", 32'(seen_lo), 1);
    chk("square_high_seen", 32'(seen_hi), 1);

    for (int i = 0; i < 40; i++) begin
      set_mode($urandom_range(0, 3));
      r = $urandom_range(0, 3);
      set_sel(r[1], r[0]);
      turn(($urandom_range(0, 1) != 0 ? 1 : -1) * $urandom_range(1, 20), $urandom_range(1, 3));
      repeat (6) @(negedge clk);
      chk("rand_fcount", 32'(fcount), 32'(f_m));
      chk("rand_acount", 32'(acount), 32'(a_m));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end

    set_sel(1'b0, 1'b0);
    {A, B} = 2'b00;
    pos = 0;
    set_mode(3);
    for (int t = 0; t < 2 * PER && !sync_n; t++) @(negedge clk);
    for (int t = 0; t < 2 * PER && sync_n; t++) @(negedge clk);
    chk("sync_fell", 32'(sync_n), 0);
    repeat (7 * 4) @(negedge clk);
    pulses0 = ldac_pulses;
    #2 rst = 1'b1;
    f_m = 1; a_m = 255; phase_m = 0;
    evq.delete();
    expq.delete();
    #1;
    chk("abort_sync", 32'(sync_n), 1);
    chk("abort_sclk", 32'(sclk), 1);
    chk("abort_din", 32'(din), 0);
    chk("abort_ldac", 32'(ldac_n), 1);
    chk("abort_fcount", 32'(fcount), 1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait_frames(1);
    chk("abort_no_ldac", 32'(ldac_pulses), 32'(pulses0));
    chk("post_reset_frame", 32'(last_word), 32'h07F8);
    wait_frames(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
